// File: rtl/inst_loader.sv
// Boot loader: length-prefixed byte stream -> little-endian 32-bit words into imem,
// XOR checksum check, core held in reset until a verified image is resident.
module inst_loader_lane (
  input  logic       clock,
  input  logic       reset,
  input  logic       sel,
  input  logic [7:0] din,
  output logic [7:0] q,
  output logic [7:0] nxt
);
  // nxt lets the 4th byte land in the written word on the same edge it arrives
  assign nxt = sel ? din : q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)   q <= '0;
    else if (sel) q <= din;
  end
endmodule

module inst_loader #(
  parameter int unsigned MAX_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_run,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] loaded_words
);
  localparam int NUM_LANES = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] len_n;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [7:0]  csum;
  logic        acc;
  logic [15:0] n_hdr;
  logic [NUM_LANES-1:0]       lane_sel;
  logic [NUM_LANES-1:0][7:0]  lane_q;
  logic [NUM_LANES-1:0][7:0]  word_nxt;

  assign byte_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                      (state == S_DATA)   || (state == S_CSUM);
  assign busy   = byte_ready || (state == S_WRITE);
  assign mem_we = (state == S_WRITE);
  assign acc    = byte_valid && byte_ready;
  assign n_hdr  = {byte_data, len_lo};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_sel[i] = acc && (state == S_DATA) && (byte_idx == 2'(i));
    inst_loader_lane u_lane (
      .clock (clock),
      .reset (reset),
      .sel   (lane_sel[i]),
      .din   (byte_data),
      .q     (lane_q[i]),
      .nxt   (word_nxt[i])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      len_lo       <= '0;
      len_n        <= '0;
      word_idx     <= '0;
      byte_idx     <= '0;
      csum         <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      core_run     <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      loaded_words <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: if (start) begin
          state        <= S_LEN_LO;
          word_idx     <= '0;
          byte_idx     <= '0;
          csum         <= '0;
          loaded_words <= '0;
          done         <= 1'b0;
          error        <= 1'b0;
          core_run     <= 1'b0;
        end
        S_LEN_LO: if (acc) begin
          len_lo <= byte_data;
          state  <= S_LEN_HI;
        end
        S_LEN_HI: if (acc) begin
          len_n <= n_hdr;
          if (n_hdr == 16'd0 || {16'd0, n_hdr} > 32'(MAX_WORDS)) begin
            state <= S_ERR;
            error <= 1'b1;
          end else begin
            state <= S_DATA;
          end
        end
        S_DATA: if (acc) begin
          csum     <= csum ^ byte_data;
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            mem_addr  <= BASE_ADDR + {14'd0, word_idx, 2'b00};
            mem_wdata <= word_nxt;
            state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          word_idx     <= word_idx + 16'd1;
          loaded_words <= loaded_words + 16'd1;
          state        <= (word_idx + 16'd1 == len_n) ? S_CSUM : S_DATA;
        end
        S_CSUM: if (acc) begin
          if (byte_data == csum) begin
            state    <= S_DONE;
            done     <= 1'b1;
            core_run <= 1'b1;
          end else begin
            state <= S_ERR;
            error <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: good/bad checksum, bad lengths, stalls,
// async reset mid-load and reload from DONE.
module tb_inst_loader;
  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_run;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] loaded_words;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [31:0] img [0:3];
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];

  inst_loader #(.MAX_WORDS(256), .BASE_ADDR(32'h0000_0000)) dut (
    .clock(clock), .reset(reset), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_run(core_run), .busy(busy), .done(done), .error(error),
    .loaded_words(loaded_words)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // write log; WRITE must never advertise ready
  always @(negedge clock) if (reset && mem_we) begin
    wr_addr.push_back(mem_addr);
    wr_data.push_back(mem_wdata);
    chk("ready_in_write", {31'd0, byte_ready}, 32'd0);
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int budget = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clock);
    while (!byte_ready && budget < 50) begin
      @(negedge clock);
      budget++;
    end
    if (!byte_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      byte_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    acc_cyc = cyc;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) @(posedge clock);
      #1;
    end
  endtask

  function automatic logic [7:0] img_csum(input int n);
    logic [7:0] x = 8'h00;
    for (int w = 0; w < n; w++)
      for (int b = 0; b < 4; b++) x ^= img[w][8*b +: 8];
    return x;
  endfunction

  task automatic do_start();
    byte_valid = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("start_core_run", {31'd0, core_run}, 32'd0);
    chk("start_busy", {31'd0, busy}, 32'd1);
  endtask

  task automatic send_image(input int n, input logic [7:0] bad, input int gapmax);
    int k = 0;
    int first;
    send_byte(8'(n), 0);
    first = acc_cyc;
    send_byte(8'(n >> 8), 0);
    for (int w = 0; w < n; w++)
      for (int b = 0; b < 4; b++) begin
        send_byte(img[w][8*b +: 8], (gapmax > 0) ? (k % (gapmax + 1)) : 0);
        k++;
      end
    send_byte(img_csum(n) ^ bad, 0);
    byte_valid = 1'b0;
    if (gapmax == 0 && bad == 8'h00)
      chk("load_cycles", 32'(acc_cyc - first + 1), 32'(2 + 5*n + 1));
  endtask

  task automatic chk_writes(input string tag, input int n);
    chk({tag, "_nwr"}, 32'(wr_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      chk({tag, "_addr"}, wr_addr[i], 32'(4*i));
      chk({tag, "_data"}, wr_data[i], img[i]);
    end
  endtask

  task automatic chk_final(input string tag, input logic d, input logic e, input int lw);
    chk({tag, "_done"}, {31'd0, done}, {31'd0, d});
    chk({tag, "_core_run"}, {31'd0, core_run}, {31'd0, d});
    chk({tag, "_error"}, {31'd0, error}, {31'd0, e});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_loaded"}, {16'd0, loaded_words}, 32'(lw));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
    chk({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_flags"}, {28'd0, core_run, busy, done, error}, 32'd0);
    chk({tag, "_loaded"}, {16'd0, loaded_words}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    #2;
    chk_zero("reset");
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // bytes offered in IDLE are refused
    byte_valid = 1'b1; byte_data = 8'h55;
    repeat (3) @(posedge clock);
    #1;
    chk("idle_ready", {31'd0, byte_ready}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    byte_valid = 1'b0;

    img[0] = 32'h0050_0013; img[1] = 32'h0010_0093;
    img[2] = 32'h0020_81B3; img[3] = 32'h0000_006F;

    do_start();
    send_image(2, 8'h00, 0);
    chk_writes("good", 2);
    chk_final("good", 1'b1, 1'b0, 2);

    do_start();
    send_image(2, 8'h01, 0);
    chk_writes("badsum", 2);
    chk_final("badsum", 1'b0, 1'b1, 2);

    do_start();
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    byte_valid = 1'b0;
    chk("len0_nwr", 32'(wr_addr.size()), 32'd0);
    chk_final("len0", 1'b0, 1'b1, 0);

    do_start();
    send_byte(8'h01, 0); send_byte(8'h01, 0);
    byte_valid = 1'b0;
    chk("len257_nwr", 32'(wr_addr.size()), 32'd0);
    chk_final("len257", 1'b0, 1'b1, 0);

    do_start();
    send_image(2, 8'h00, 3);
    chk_writes("stall", 2);
    chk_final("stall", 1'b1, 1'b0, 2);

    // async reset in the middle of word 2 of a 4-word image
    do_start();
    send_byte(8'h04, 0); send_byte(8'h00, 0);
    for (int b = 0; b < 4; b++) send_byte(img[0][8*b +: 8], 0);
    send_byte(img[1][7:0], 0);
    send_byte(img[1][15:8], 0);
    chk("mid_loaded", {16'd0, loaded_words}, 32'd1);
    chk("mid_wdata", mem_wdata, img[0]);
    #2 reset = 1'b0;
    #1 chk_zero("async");
    byte_valid = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    do_start();
    send_image(4, 8'h00, 0);
    chk_writes("reload4", 4);
    chk_final("reload4", 1'b1, 1'b0, 4);

    // restart from DONE; start held during DATA must be ignored
    img[0] = 32'h0000_006F;
    do_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    start = 1'b1;
    for (int b = 0; b < 4; b++) send_byte(img[0][8*b +: 8], 0);
    chk("start_ignored_busy", {31'd0, busy}, 32'd1);
    start = 1'b0;
    send_byte(8'h6F, 0);
    byte_valid = 1'b0;
    chk_writes("one", 1);
    chk_final("one", 1'b1, 1'b0, 1);

    repeat (2) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
